// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Brief    : Shared OCW2 command codes, handshake states and priority helper
//            for the PIC priority sequencer.
// Revision : 1.0
// ============================================================================
package pic_pkg;

   localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   localparam logic [2:0] SPURIOUS_LEVEL    = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK1  = 2'd1,
      WAIT2 = 2'd2,
      ACK2  = 2'd3
   } pic_state_t;

   // Rank 0 is the highest priority: the level just above the lowest pointer.
   function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                            input logic [2:0] lowest);
      return level - lowest - 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_resolver
// Brief    : Combinational rotating-priority encoder; returns the highest
//            ranked set bit given the current lowest-priority level.
// Revision : 1.0
// ============================================================================
module pic_priority_resolver
   import pic_pkg::*;
(
   input  logic [7:0] i_vec,
   input  logic [2:0] i_lowest,
   output logic       o_valid,
   output logic [2:0] o_level
);

   // Scan from lowest to highest rank so the last hit is the winner.
   always_comb begin
      o_valid = 1'b0;
      o_level = SPURIOUS_LEVEL;
      for (int i = 0; i < 8; i++) begin
         if (i_vec[i_lowest - 3'(i)]) begin
            o_valid = 1'b1;
            o_level = i_lowest - 3'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pic_priority_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_sequencer
// Brief    : 8259-style IRR/ISR ownership, priority resolution, INTA
//            handshake and vector drive. Rotation enabled by PIC_AUTO_ROTATE_EN.
// Revision : 1.0
// ============================================================================
module pic_priority_sequencer
   import pic_pkg::*;
#(
   parameter int NUM_IR = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_IR-1:0] ir_lines,
   input  logic              level_trigger_flag,
   input  logic [NUM_IR-1:0] imr,
   input  logic [4:0]        vector_base,
   input  logic              aeoi_flag,
   input  logic              ready_to_accept_interrupts_flag,
   input  logic              ocw2_strobe,
   input  logic [2:0]        control_bits,
   input  logic [2:0]        ir_level,
   input  logic              inta_neg,
   output logic              int_out,
   output logic [7:0]        data_out,
   output logic              data_out_en,
   output logic [NUM_IR-1:0] irr,
   output logic [NUM_IR-1:0] isr
);

   pic_state_t        r_state;
   logic [NUM_IR-1:0] r_irr;
   logic [NUM_IR-1:0] r_isr;
   logic [NUM_IR-1:0] r_ir_prev;
   logic [7:0]        r_data_out;
   logic              r_data_out_en;
   logic              r_int_out;
   logic              r_inta_q;
   logic              r_spurious;
   logic [2:0]        r_cur_level;
   logic [2:0]        r_prio_l;
`ifdef PIC_AUTO_ROTATE_EN
   logic              r_rot_aeoi;
`endif

   logic [NUM_IR-1:0] w_req;
   logic              w_win_valid;
   logic [2:0]        w_win_level;
   logic              w_isr_valid;
   logic [2:0]        w_isr_level;
   logic              w_inta_fall;
   logic              w_inta_rise;
   logic              w_nested_ok;
   logic              w_int_cond;
   logic              w_ack_take;
   logic              w_aeoi_fire;
   logic [NUM_IR-1:0] w_eoi_clr;
   logic              w_ocw_l_wr;
   logic [2:0]        w_ocw_l_val;
   logic [NUM_IR-1:0] w_irr_next;
   logic [NUM_IR-1:0] w_isr_next;

   assign w_req = r_irr & ~imr;

   pic_priority_resolver u_req_resolver (
      .i_vec    (w_req),
      .i_lowest (r_prio_l),
      .o_valid  (w_win_valid),
      .o_level  (w_win_level)
   );

   pic_priority_resolver u_isr_resolver (
      .i_vec    (r_isr),
      .i_lowest (r_prio_l),
      .o_valid  (w_isr_valid),
      .o_level  (w_isr_level)
   );

   assign w_inta_fall = r_inta_q & ~inta_neg;
   assign w_inta_rise = ~r_inta_q & inta_neg;

   // Fully nested: a request must strictly outrank everything in service.
   assign w_nested_ok = ~w_isr_valid |
                        (prio_rank(w_win_level, r_prio_l) < prio_rank(w_isr_level, r_prio_l));
   assign w_int_cond  = (r_state == IDLE) & ready_to_accept_interrupts_flag &
                        w_win_valid & w_nested_ok;
   assign w_ack_take  = (r_state == IDLE) & ready_to_accept_interrupts_flag & w_inta_fall;
   assign w_aeoi_fire = (r_state == ACK2) & ready_to_accept_interrupts_flag & w_inta_rise &
                        aeoi_flag & ~r_spurious;

   // OCW2 decode; EOIs work on the ISR as it stood at the start of the cycle.
   always_comb begin
      w_eoi_clr   = '0;
      w_ocw_l_wr  = 1'b0;
      w_ocw_l_val = r_prio_l;
      if (ocw2_strobe) begin
         case (control_bits)
            OCW2_NS_EOI: begin
               if (w_isr_valid) w_eoi_clr[w_isr_level] = 1'b1;
            end
            OCW2_SP_EOI: begin
               w_eoi_clr[ir_level] = 1'b1;
            end
            OCW2_ROT_NS_EOI: begin
               if (w_isr_valid) begin
                  w_eoi_clr[w_isr_level] = 1'b1;
`ifdef PIC_AUTO_ROTATE_EN
                  w_ocw_l_wr  = 1'b1;
                  w_ocw_l_val = w_isr_level;
`endif
               end
            end
            OCW2_ROT_SP_EOI: begin
               w_eoi_clr[ir_level] = 1'b1;
`ifdef PIC_AUTO_ROTATE_EN
               w_ocw_l_wr  = 1'b1;
               w_ocw_l_val = ir_level;
`endif
            end
            OCW2_SET_PRIO: begin
`ifdef PIC_AUTO_ROTATE_EN
               w_ocw_l_wr  = 1'b1;
               w_ocw_l_val = ir_level;
`endif
            end
            OCW2_SET_ROT_AEOI, OCW2_CLR_ROT_AEOI, OCW2_NOP: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      if (level_trigger_flag) begin
         w_irr_next = ir_lines;
      end else begin
         w_irr_next = ir_lines & (r_irr | ~r_ir_prev);
         if (w_ack_take && w_win_valid) w_irr_next[w_win_level] = 1'b0;
      end
   end

   always_comb begin
      w_isr_next = r_isr & ~w_eoi_clr;
      if (w_aeoi_fire) w_isr_next[r_cur_level] = 1'b0;
      if (w_ack_take && w_win_valid) w_isr_next[w_win_level] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_irr         <= '0;
         r_isr         <= '0;
         r_ir_prev     <= '0;
         r_data_out    <= 8'h00;
         r_data_out_en <= 1'b0;
         r_int_out     <= 1'b0;
         r_inta_q      <= 1'b1;
         r_spurious    <= 1'b0;
         r_cur_level   <= SPURIOUS_LEVEL;
         r_prio_l      <= 3'd7;
`ifdef PIC_AUTO_ROTATE_EN
         r_rot_aeoi    <= 1'b0;
`endif
      end else begin
         r_ir_prev <= ir_lines;
         r_inta_q  <= inta_neg;
         r_int_out <= w_int_cond & ~w_ack_take;
         r_irr     <= w_irr_next;
         r_isr     <= w_isr_next;

         if (!ready_to_accept_interrupts_flag) begin
            r_state       <= IDLE;
            r_data_out_en <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_inta_fall) begin
                     r_state     <= ACK1;
                     r_cur_level <= w_win_valid ? w_win_level : SPURIOUS_LEVEL;
                     r_spurious  <= ~w_win_valid;
                  end
               end
               ACK1: begin
                  if (w_inta_rise) r_state <= WAIT2;
               end
               WAIT2: begin
                  if (w_inta_fall) begin
                     r_state       <= ACK2;
                     r_data_out    <= {vector_base, r_cur_level};
                     r_data_out_en <= 1'b1;
                  end
               end
               ACK2: begin
                  if (w_inta_rise) begin
                     r_state       <= IDLE;
                     r_data_out_en <= 1'b0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end

         if (w_ocw_l_wr) begin
            r_prio_l <= w_ocw_l_val;
         end
`ifdef PIC_AUTO_ROTATE_EN
         else if (w_aeoi_fire && r_rot_aeoi) begin
            r_prio_l <= r_cur_level;
         end

         if (ocw2_strobe && control_bits == OCW2_SET_ROT_AEOI) begin
            r_rot_aeoi <= 1'b1;
         end else if (ocw2_strobe && control_bits == OCW2_CLR_ROT_AEOI) begin
            r_rot_aeoi <= 1'b0;
         end
`endif
      end
   end

   assign int_out     = r_int_out;
   assign data_out    = r_data_out;
   assign data_out_en = r_data_out_en;
   assign irr         = r_irr;
   assign isr         = r_isr;

endmodule
`default_nettype wire

// File: tb/tb_pic_priority_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_priority_sequencer
// Brief    : Self-checking bench: vector table plus handshake sequences, with
//            expected INTA vectors queued and compared when the bus is driven.
// Revision : 1.0
// ============================================================================
module tb_pic_priority_sequencer;
   import pic_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ir_lines;
   logic       level_trigger_flag;
   logic [7:0] imr;
   logic [4:0] vector_base;
   logic       aeoi_flag;
   logic       ready;
   logic       ocw2_strobe;
   logic [2:0] control_bits;
   logic [2:0] ir_level;
   logic       inta_neg;
   logic       int_out;
   logic [7:0] data_out;
   logic       data_out_en;
   logic [7:0] irr;
   logic [7:0] isr;

   typedef struct {
      logic [7:0] ir;
      logic [7:0] mask;
      logic       exp_int;
      logic [7:0] exp_vec;
   } vec_t;

   vec_t       tbl[7];
   logic [7:0] sb_q[$];
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   pic_priority_sequencer #(.NUM_IR(8)) dut (
      .clk                             (clk),
      .reset                           (reset),
      .ir_lines                        (ir_lines),
      .level_trigger_flag              (level_trigger_flag),
      .imr                             (imr),
      .vector_base                     (vector_base),
      .aeoi_flag                       (aeoi_flag),
      .ready_to_accept_interrupts_flag (ready),
      .ocw2_strobe                     (ocw2_strobe),
      .control_bits                    (control_bits),
      .ir_level                        (ir_level),
      .inta_neg                        (inta_neg),
      .int_out                         (int_out),
      .data_out                        (data_out),
      .data_out_en                     (data_out_en),
      .irr                             (irr),
      .isr                             (isr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
      ocw2_strobe  = 1'b1;
      control_bits = cmd;
      ir_level     = lvl;
      tick();
      ocw2_strobe  = 1'b0;
   endtask

   // Two INTA pulses; the expected vector is queued when the second fall is driven.
   task automatic inta_pair(input string name, input logic [7:0] exp_vec, input logic [7:0] exp_isr);
      logic [7:0] exp;
      inta_neg = 1'b0;
      tick();
      check({name, " isr after 1st fall"}, isr, exp_isr);
      inta_neg = 1'b1;
      tick();
      check({name, " int_out low in handshake"}, int_out, 1'b0);
      inta_neg = 1'b0;
      sb_q.push_back(exp_vec);
      tick();
      if (data_out_en) begin
         exp = sb_q.pop_front();
         check({name, " vector"}, data_out, exp);
      end else begin
         check({name, " data_out_en on 2nd pulse"}, data_out_en, 1'b1);
      end
      inta_neg = 1'b1;
      tick();
      check({name, " data_out_en after rise"}, data_out_en, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{ir: 8'h01, mask: 8'h00, exp_int: 1'b1, exp_vec: 8'h40};
      tbl[1] = '{ir: 8'h81, mask: 8'h01, exp_int: 1'b1, exp_vec: 8'h47};
      tbl[2] = '{ir: 8'hF0, mask: 8'h00, exp_int: 1'b1, exp_vec: 8'h44};
      tbl[3] = '{ir: 8'hFF, mask: 8'hFF, exp_int: 1'b0, exp_vec: 8'h00};
      tbl[4] = '{ir: 8'h00, mask: 8'h00, exp_int: 1'b0, exp_vec: 8'h00};
      tbl[5] = '{ir: 8'h06, mask: 8'h02, exp_int: 1'b1, exp_vec: 8'h42};
      tbl[6] = '{ir: 8'h80, mask: 8'h00, exp_int: 1'b1, exp_vec: 8'h47};

      reset              = 1'b1;
      ir_lines           = 8'h00;
      level_trigger_flag = 1'b0;
      imr                = 8'h00;
      vector_base        = 5'b01000;
      aeoi_flag          = 1'b0;
      ready              = 1'b1;
      ocw2_strobe        = 1'b0;
      control_bits       = 3'b000;
      ir_level           = 3'd0;
      inta_neg           = 1'b1;
      tick_n(2);
      check("reset int_out", int_out, 1'b0);
      check("reset data_out", data_out, 8'h00);
      check("reset data_out_en", data_out_en, 1'b0);
      check("reset irr", irr, 8'h00);
      check("reset isr", isr, 8'h00);
      reset = 1'b0;

      // Edge mode IR3: int_out two clocks after the line rises.
      ir_lines = 8'h08;
      tick();
      check("ir3 irr set", irr, 8'h08);
      check("ir3 int_out not yet", int_out, 1'b0);
      tick();
      check("ir3 int_out", int_out, 1'b1);
      inta_pair("ir3", 8'h43, 8'h08);
      check("ir3 isr after ack", isr, 8'h08);
      check("ir3 irr cleared", irr, 8'h00);
      ocw2(OCW2_SP_EOI, 3'd3);
      check("specific eoi isr", isr, 8'h00);

      // Nested: IR5 in service, IR2 and IR6 request.
      ir_lines = 8'h20;
      tick_n(2);
      check("ir5 int_out", int_out, 1'b1);
      inta_pair("ir5", 8'h45, 8'h20);
      ir_lines = 8'h64;
      tick_n(2);
      check("nested irr", irr, 8'h44);
      check("nested int_out for ir2", int_out, 1'b1);
      inta_pair("ir2 nested", 8'h42, 8'h24);
      tick_n(2);
      check("ir6 blocked int_out", int_out, 1'b0);
      check("ir6 pending irr", irr, 8'h40);
      ocw2(OCW2_NS_EOI, 3'd0);
      check("ns eoi clears ir2", isr, 8'h20);
      ocw2(OCW2_NS_EOI, 3'd0);
      check("ns eoi clears ir5", isr, 8'h00);

      // Level-mode vector table.
      level_trigger_flag = 1'b1;
      ir_lines = 8'h00;
      tick_n(2);
      for (int k = 0; k < 7; k++) begin
         ir_lines = tbl[k].ir;
         imr      = tbl[k].mask;
         tick_n(2);
         check($sformatf("tbl[%0d] int_out", k), int_out, tbl[k].exp_int);
         if (tbl[k].exp_int) begin
            inta_pair($sformatf("tbl[%0d]", k), tbl[k].exp_vec, 8'h01 << tbl[k].exp_vec[2:0]);
            ocw2(OCW2_NS_EOI, 3'd0);
            check($sformatf("tbl[%0d] isr cleared", k), isr, 8'h00);
         end
         ir_lines = 8'h00;
         imr      = 8'h00;
         tick_n(2);
      end

      // Spurious: edge request withdrawn before the first INTA fall.
      level_trigger_flag = 1'b0;
      ir_lines = 8'h02;
      tick_n(2);
      check("ir1 int_out", int_out, 1'b1);
      ir_lines = 8'h00;
      tick();
      inta_pair("spurious", 8'h47, 8'h00);
      check("spurious isr unchanged", isr, 8'h00);

      // Automatic EOI.
      aeoi_flag = 1'b1;
      ir_lines  = 8'h01;
      tick_n(2);
      check("aeoi int_out", int_out, 1'b1);
      inta_pair("aeoi ir0", 8'h40, 8'h01);
      check("aeoi isr cleared", isr, 8'h00);
      aeoi_flag = 1'b0;
      ir_lines  = 8'h00;
      tick_n(2);

      // Rotate on non-specific EOI, then IR3 vs IR5.
      ir_lines = 8'h10;
      tick_n(2);
      inta_pair("ir4", 8'h44, 8'h10);
      ocw2(OCW2_ROT_NS_EOI, 3'd0);
      check("rot ns eoi isr", isr, 8'h00);
      ir_lines = 8'h28;
      tick_n(2);
      check("rot int_out", int_out, 1'b1);
`ifdef PIC_AUTO_ROTATE_EN
      inta_pair("rotated winner", 8'h45, 8'h20);
`else
      inta_pair("fixed winner", 8'h43, 8'h08);
`endif
      ocw2(OCW2_NS_EOI, 3'd0);
      check("post rot isr", isr, 8'h00);
      ir_lines = 8'h00;
      tick_n(2);

      // Reset while waiting for the second INTA pulse.
      ir_lines = 8'h04;
      tick_n(2);
      inta_neg = 1'b0;
      tick();
      inta_neg = 1'b1;
      tick();
      check("wait2 isr", isr, 8'h04);
      reset    = 1'b1;
      ir_lines = 8'h00;
      tick();
      reset    = 1'b0;
      check("mid reset int_out", int_out, 1'b0);
      check("mid reset data_out", data_out, 8'h00);
      check("mid reset data_out_en", data_out_en, 1'b0);
      check("mid reset irr", irr, 8'h00);
      check("mid reset isr", isr, 8'h00);
      inta_neg = 1'b0;
      tick();
      check("post reset pulse low en", data_out_en, 1'b0);
      inta_neg = 1'b1;
      tick();
      check("post reset pulse high en", data_out_en, 1'b0);
      tick();
      check("post reset idle en", data_out_en, 1'b0);
      check("scoreboard drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
